// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register map, bit indices and FSM states shared by the uart_mmio slice
package uart_pkg;

    localparam logic [4:0] OFF_TXDATA = 5'h00;
    localparam logic [4:0] OFF_RXDATA = 5'h04;
    localparam logic [4:0] OFF_STATUS = 5'h08;
    localparam logic [4:0] OFF_CTRL   = 5'h0C;
    localparam logic [4:0] OFF_BAUD   = 5'h10;

    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_RX_NEMPTY  = 2;
    localparam int ST_TX_BUSY    = 3;
    localparam int ST_OVERRUN    = 4;
    localparam int ST_FRAME_ERR  = 5;
    localparam int ST_PARITY_ERR = 6;

    localparam int CT_TX_EN     = 0;
    localparam int CT_RX_EN     = 1;
    localparam int CT_PAR_EN    = 2;
    localparam int CT_PAR_ODD   = 3;
    localparam int CT_IRQ_RX_EN = 4;
    localparam int CT_IRQ_TX_EN = 5;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with same-cycle push/pop, used for UART RX and TX
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/uart_mmio.sv
// rtl/uart_mmio.sv - memory-mapped UART with baud divisor, 16x oversampling, parity, FIFOs and irq
module uart_mmio
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h40000020,
    parameter int          DATA_BITS   = 8,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        rxd,
    output logic        txd,
    output logic        irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0] off;
    logic        in_win;
    logic [4:0]  reg_off;
    logic        wr_status, wr_ctrl, wr_baud;
    logic [5:0]  ctrl;
    logic [15:0] baud_div;
    logic        ovr, fe, pe;
    logic        unused_wdata;

    assign off       = addr - BASE_ADDR;
    assign in_win    = (off < 32'd20) && (off[1:0] == 2'b00);
    assign reg_off   = off[4:0];
    assign wr_status = wr && in_win && (reg_off == OFF_STATUS);
    assign wr_ctrl   = wr && in_win && (reg_off == OFF_CTRL);
    assign wr_baud   = wr && in_win && (reg_off == OFF_BAUD);
    assign unused_wdata = ^wdata[31:16];

    logic                 tx_push, tx_pop, tx_full, tx_empty;
    logic [DATA_BITS-1:0] tx_head;
    logic [CW-1:0]        tx_count;
    logic                 rx_push, rx_pop, rx_full, rx_empty;
    logic [DATA_BITS-1:0] rx_head, rx_sh;
    logic [CW-1:0]        rx_count;

    assign tx_push = wr && in_win && (reg_off == OFF_TXDATA);
    assign rx_pop  = rd && in_win && (reg_off == OFF_RXDATA);

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(tx_push), .push_data(wdata[DATA_BITS-1:0]),
        .pop(tx_pop), .head(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count));

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .push_data(rx_sh),
        .pop(rx_pop), .head(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count));

    // Free-running prescaler shared by both directions; a new divisor lands on the next reload.
    logic [15:0] tick_cnt;
    logic        tick;
    assign tick = (tick_cnt == 16'd0);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tick_cnt <= DEFAULT_DIV;
        else        tick_cnt <= tick ? baud_div : tick_cnt - 16'd1;
    end

    tx_state_t            tx_state;
    logic [3:0]           tx_tcnt;
    logic [2:0]           tx_bit;
    logic [DATA_BITS-1:0] tx_sh;
    logic                 tx_par, tx_par_en, tx_bit_end, tx_busy;

    assign tx_busy    = (tx_state != TX_IDLE);
    assign tx_bit_end = tick && (tx_tcnt == 4'd15);
    assign tx_pop     = (tx_state == TX_IDLE) && ctrl[CT_TX_EN] && (tx_count != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state  <= TX_IDLE;
            txd       <= 1'b1;
            tx_tcnt   <= '0;
            tx_bit    <= '0;
            tx_sh     <= '0;
            tx_par    <= 1'b0;
            tx_par_en <= 1'b0;
        end else begin
            if (tx_busy && tick) tx_tcnt <= tx_tcnt + 4'd1;
            case (tx_state)
                TX_IDLE: begin
                    txd <= 1'b1;
                    if (tx_pop) begin
                        tx_sh     <= tx_head;
                        tx_par    <= (^tx_head) ^ ctrl[CT_PAR_ODD];
                        tx_par_en <= ctrl[CT_PAR_EN];
                        tx_tcnt   <= '0;
                        txd       <= 1'b0;
                        tx_state  <= TX_START;
                    end
                end
                TX_START: if (tx_bit_end) begin
                    txd      <= tx_sh[0];
                    tx_bit   <= '0;
                    tx_state <= TX_DATA;
                end
                TX_DATA: if (tx_bit_end) begin
                    tx_sh <= tx_sh >> 1;
                    if (tx_bit == 3'(DATA_BITS-1)) begin
                        txd      <= tx_par_en ? tx_par : 1'b1;
                        tx_state <= tx_par_en ? TX_PARITY : TX_STOP;
                    end else begin
                        txd    <= tx_sh[1];
                        tx_bit <= tx_bit + 3'd1;
                    end
                end
                TX_PARITY: if (tx_bit_end) begin
                    txd      <= 1'b1;
                    tx_state <= TX_STOP;
                end
                TX_STOP: if (tx_bit_end) tx_state <= TX_IDLE;
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    logic      rx_s1, rx_s2, rx_s3;
    rx_state_t rx_state;
    logic [3:0] rx_tcnt;
    logic [2:0] rx_bit;
    logic      rx_par_bit, rx_par_en, rx_par_odd;
    logic      rx_sample, rx_stop_smp, rx_par_bad, rx_good, ovr_set, fe_set, pe_set;

    // START counts 8 ticks to mid-bit; later bits are 16 ticks apart from there.
    assign rx_sample   = tick && (rx_tcnt == ((rx_state == RX_START) ? 4'd7 : 4'd15));
    assign rx_stop_smp = (rx_state == RX_STOP) && rx_sample;
    assign rx_par_bad  = rx_par_en && (rx_par_bit != ((^rx_sh) ^ rx_par_odd));
    assign fe_set      = rx_stop_smp && !rx_s2;
    assign pe_set      = rx_stop_smp && rx_s2 && rx_par_bad;
    assign rx_good     = rx_stop_smp && rx_s2 && !rx_par_bad;
    assign ovr_set     = rx_good && rx_full;
    assign rx_push     = rx_good && !rx_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {rx_s3, rx_s2, rx_s1} <= 3'b111;
            rx_state   <= RX_IDLE;
            rx_tcnt    <= '0;
            rx_bit     <= '0;
            rx_sh      <= '0;
            rx_par_bit <= 1'b0;
            rx_par_en  <= 1'b0;
            rx_par_odd <= 1'b0;
        end else begin
            {rx_s3, rx_s2, rx_s1} <= {rx_s2, rx_s1, rxd};
            if ((rx_state != RX_IDLE) && tick) rx_tcnt <= rx_tcnt + 4'd1;
            case (rx_state)
                RX_IDLE: if (ctrl[CT_RX_EN] && rx_s3 && !rx_s2) begin
                    rx_tcnt    <= '0;
                    rx_par_en  <= ctrl[CT_PAR_EN];
                    rx_par_odd <= ctrl[CT_PAR_ODD];
                    rx_state   <= RX_START;
                end
                RX_START: if (rx_sample) begin
                    rx_tcnt  <= '0;
                    rx_bit   <= '0;
                    rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (rx_sample) begin
                    rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
                    if (rx_bit == 3'(DATA_BITS-1)) rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
                    else                           rx_bit   <= rx_bit + 3'd1;
                end
                RX_PARITY: if (rx_sample) begin
                    rx_par_bit <= rx_s2;
                    rx_state   <= RX_STOP;
                end
                RX_STOP: if (rx_sample) rx_state <= RX_IDLE;
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl     <= '0;
            baud_div <= DEFAULT_DIV;
            ovr      <= 1'b0;
            fe       <= 1'b0;
            pe       <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl     <= wdata[5:0];
            if (wr_baud) baud_div <= wdata[15:0];
            if (ovr_set)                                ovr <= 1'b1;
            else if (wr_status && wdata[ST_OVERRUN])    ovr <= 1'b0;
            if (fe_set)                                 fe  <= 1'b1;
            else if (wr_status && wdata[ST_FRAME_ERR])  fe  <= 1'b0;
            if (pe_set)                                 pe  <= 1'b1;
            else if (wr_status && wdata[ST_PARITY_ERR]) pe  <= 1'b0;
            irq <= (ctrl[CT_IRQ_RX_EN] & !rx_empty)
                 | (ctrl[CT_IRQ_TX_EN] & tx_empty & !tx_busy)
                 | (ctrl[CT_IRQ_RX_EN] & (ovr | fe | pe));
        end
    end

    always_comb begin
        rdata = '0;
        if (rd && in_win) begin
            case (reg_off)
                OFF_RXDATA: if (rx_count != '0) rdata = 32'(rx_head);
                OFF_STATUS: rdata = {25'd0, pe, fe, ovr, tx_busy, !rx_empty, tx_empty, tx_full};
                OFF_CTRL:   rdata = {26'd0, ctrl};
                OFF_BAUD:   rdata = {16'd0, baud_div};
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
// tb/tb_uart_mmio.sv - scoreboard bench for uart_mmio: bus reads and serial frames checked against a reference model
`timescale 1ns/1ps
module tb_uart_mmio;
    localparam logic [31:0] BASE = 32'h40000020;
    localparam logic [31:0] A_TX = BASE;
    localparam logic [31:0] A_RX = BASE + 32'h4;
    localparam logic [31:0] A_ST = BASE + 32'h8;
    localparam logic [31:0] A_CT = BASE + 32'hC;
    localparam logic [31:0] A_BD = BASE + 32'h10;

    logic        clk = 1'b0, reset = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic        rxd, txd, irq;
    logic        loop = 1'b0, rxd_drv = 1'b1;

    assign rxd = loop ? txd : rxd_drv;
    always #5 clk = ~clk;

    uart_mmio #(.BASE_ADDR(BASE), .DATA_BITS(8), .FIFO_DEPTH(8), .DEFAULT_DIV(16'd26)) dut (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .rxd(rxd), .txd(txd), .irq(irq));

    int n_checks = 0, n_pass = 0, tx_frames = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference model: RX FIFO contents, sticky error flags, expected TX frames.
    logic [7:0] rx_m[$];
    logic [7:0] tx_q[$];
    logic       m_ovr = 1'b0, m_fe = 1'b0, m_pe = 1'b0;
    logic       mon_par_en = 1'b0, mon_par_odd = 1'b0;

    function automatic void model_rx(input logic [7:0] d, input logic stop_ok, input logic par_ok);
        if (!stop_ok)             m_fe = 1'b1;
        else if (!par_ok)         m_pe = 1'b1;
        else if (rx_m.size() >= 8) m_ovr = 1'b1;
        else                      rx_m.push_back(d);
    endfunction

    function automatic logic [31:0] model_status(input logic full, input logic empty, input logic busy);
        return {25'd0, m_pe, m_fe, m_ovr, busy, rx_m.size() != 0, empty, full};
    endfunction

    typedef struct {
        string       name;
        logic [31:0] val;
        logic [31:0] mask;
    } rd_exp_t;
    rd_exp_t rd_q[$];

    always @(negedge clk) begin
        rd_exp_t e;
        if (rd) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected read: got 0x%0h expected no read", rdata);
            end else begin
                e = rd_q.pop_front();
                if (e.mask != 0) chk(e.name, rdata & e.mask, e.val & e.mask);
            end
        end
    end

    initial begin
        forever begin
            logic [7:0] b, e;
            logic       pen, podd, pbit;
            @(negedge txd);
            pen = mon_par_en;
            podd = mon_par_odd;
            pbit = 1'b0;
            repeat (16) @(negedge clk);
            chk("tx start bit", txd, 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (32) @(negedge clk);
                b[i] = txd;
            end
            if (pen) begin
                repeat (32) @(negedge clk);
                pbit = txd;
            end
            repeat (32) @(negedge clk);
            chk("tx stop bit", txd, 1'b1);
            tx_frames++;
            if (tx_q.size() == 0) begin
                n_checks++;
                $display("FAIL tx unexpected frame: got 0x%0h expected none", b);
            end else begin
                e = tx_q.pop_front();
                chk("tx data", b, e);
                if (pen) chk("tx parity", pbit, (^e) ^ podd);
            end
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr = 1'b1;
        @(posedge clk); #1;
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, input string name, input logic [31:0] exp,
                            input logic [31:0] mask, output logic [31:0] v);
        rd_exp_t e;
        e.name = name; e.val = exp; e.mask = mask;
        rd_q.push_back(e);
        addr = a; rd = 1'b1;
        @(negedge clk); v = rdata;
        @(posedge clk); #1;
        rd = 1'b0;
    endtask

    task automatic rd_chk(input logic [31:0] a, input string name, input logic [31:0] exp, input logic [31:0] mask);
        logic [31:0] v;
        bus_read(a, name, exp, mask, v);
    endtask

    task automatic poll(input logic [31:0] mask, input logic [31:0] val, input int budget,
                        input string name, output int cycles);
        logic [31:0] v;
        cycles = 0;
        do begin
            bus_read(A_ST, name, 32'd0, 32'd0, v);
            cycles++;
        end while (((v & mask) != val) && cycles < budget);
        if ((v & mask) != val) begin
            n_checks++;
            $display("FAIL %s: timeout after %0d cycles, got status 0x%0h expected 0x%0h under mask 0x%0h",
                     name, cycles, v, val, mask);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic podd,
                              input logic bad_par, input logic stop);
        rxd_drv = 1'b0;
        repeat (32) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = d[i];
            repeat (32) @(posedge clk);
        end
        if (pen) begin
            rxd_drv = (^d) ^ podd ^ bad_par;
            repeat (32) @(posedge clk);
        end
        rxd_drv = stop;
        repeat (32) @(posedge clk);
        rxd_drv = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        model_rx(d, stop, !(pen && bad_par));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("reset txd", txd, 1'b1);
        chk("reset irq", irq, 1'b0);
        rd_chk(A_BD, "reset baud_div", 32'd26, '1);
        rd_chk(A_ST, "reset status", 32'h02, '1);
        rd_chk(A_CT, "reset ctrl", 32'h0, '1);
        rd_chk(BASE + 32'h14, "read outside window", 32'h0, '1);
        rd_chk(A_TX, "read txdata", 32'h0, '1);
        chk("rdata with rd low", rdata, 32'h0);

        bus_write(A_BD, 32'd1);
        rd_chk(A_BD, "baud_div readback", 32'd1, '1);
        repeat (40) @(posedge clk); #1;
        bus_write(A_CT, 32'h01);
        mon_par_en = 1'b0;
        tx_q.push_back(8'hA5);
        bus_write(A_TX, 32'hA5);
        poll(32'h0A, 32'h02, 500, "tx 0xA5 completion", cyc);
        chk("tx busy duration near 320 clk", (cyc >= 310 && cyc <= 330), 1'b1);

        loop = 1'b1;
        for (int k = 0; k < 5; k++) begin
            logic [7:0] d;
            logic       pen, podd;
            d    = (k == 0) ? 8'h3C : 8'($urandom);
            pen  = (k == 0) ? 1'b1 : 1'($urandom);
            podd = (k == 0) ? 1'b1 : 1'($urandom);
            bus_write(A_CT, {26'd0, 1'b0, 1'b1, podd, pen, 1'b1, 1'b1});
            mon_par_en = pen;
            mon_par_odd = podd;
            tx_q.push_back(d);
            model_rx(d, 1'b1, 1'b1);
            bus_write(A_TX, {24'd0, d});
            poll(32'h04, 32'h04, 600, "loopback rx arrival", cyc);
            chk("irq on rx data", irq, 1'b1);
            rd_chk(A_ST, "status after loopback rx", model_status(1'b0, 1'b1, 1'b0), 32'h77);
            rd_chk(A_RX, "loopback rx data", {24'd0, rx_m.pop_front()}, '1);
            repeat (2) @(posedge clk); #1;
            chk("irq after pop", irq, 1'b0);
            poll(32'h0A, 32'h02, 400, "loopback tx idle", cyc);
        end
        loop = 1'b0;

        bus_write(A_CT, 32'h02);
        rxd_drv = 1'b0;
        repeat (12) @(posedge clk); #1;
        rxd_drv = 1'b1;
        repeat (100) @(posedge clk); #1;
        rd_chk(A_ST, "status after glitch", model_status(1'b0, 1'b1, 1'b0), '1);
        send_frame(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
        rd_chk(A_RX, "rx after glitch", {24'd0, rx_m.pop_front()}, '1);

        send_frame(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        rd_chk(A_ST, "frame error set", model_status(1'b0, 1'b1, 1'b0), '1);
        bus_write(A_ST, 32'h20);
        m_fe = 1'b0;
        rd_chk(A_ST, "frame error cleared", model_status(1'b0, 1'b1, 1'b0), '1);

        bus_write(A_CT, 32'h06);
        send_frame(8'($urandom), 1'b1, 1'b0, 1'b1, 1'b1);
        rd_chk(A_ST, "parity error set", model_status(1'b0, 1'b1, 1'b0), '1);
        bus_write(A_ST, 32'h40);
        m_pe = 1'b0;
        rd_chk(A_ST, "parity error cleared", model_status(1'b0, 1'b1, 1'b0), '1);

        bus_write(A_CT, 32'h02);
        for (int k = 0; k < 9; k++) send_frame(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
        rd_chk(A_ST, "overrun status", model_status(1'b0, 1'b1, 1'b0), '1);
        for (int k = 0; k < 8; k++) rd_chk(A_RX, "rx fifo drain", {24'd0, rx_m.pop_front()}, '1);
        rd_chk(A_RX, "rx read when empty", 32'h0, '1);
        bus_write(A_ST, 32'h10);
        m_ovr = 1'b0;
        rd_chk(A_ST, "overrun cleared", model_status(1'b0, 1'b1, 1'b0), '1);

        bus_write(A_CT, 32'h00);
        mon_par_en = 1'b0;
        for (int k = 0; k < 9; k++) begin
            logic [7:0] d;
            d = 8'($urandom);
            if (k < 8) tx_q.push_back(d);
            bus_write(A_TX, {24'd0, d});
        end
        rd_chk(A_ST, "tx full status", model_status(1'b1, 1'b0, 1'b0), '1);
        bus_write(A_CT, 32'h01);
        poll(32'h0A, 32'h02, 4000, "tx fifo drain", cyc);
        repeat (10) @(posedge clk); #1;
        chk("tx frame count", tx_frames, 14);
        chk("tx expected queue drained", tx_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
